// File: rtl/tri_sched_pkg.sv
// Shared types for the triangle scheduler: vertex/triangle layout, end-of-frame marker, FSM states.
// Pure declarations; no logic, no latency, no flow control.
package tri_sched_pkg;

    typedef struct packed {
        logic [11:0] z;
        logic [9:0]  y;
        logic [9:0]  x;
    } vertex_t;

    // Index 0 sits in the LSBs, so v0 occupies bits [31:0].
    typedef vertex_t [2:0] triangle_t;

    localparam triangle_t EOF_MARKER = 96'h0;

    typedef enum logic [2:0] {
        WAIT_VS,
        CLEAR,
        FETCH,
        WAIT_RD,
        ISSUE,
        DRAIN,
        WAIT_SWAP
    } sched_state_t;

endpackage

// File: rtl/triangle_scheduler_if.sv
// Triangle FIFO read port and pipeline hand-off bundled as one link.
// master = scheduler side, slave = FIFO/pipeline side; valid/ready on the pipeline half.
interface triangle_scheduler_if;
    import tri_sched_pkg::*;

    logic      fifo_empty;
    logic      fifo_rd_en;
    triangle_t fifo_dout;
    triangle_t triangle_coords;
    logic      tri_valid;
    logic      t_r;
    logic      pipe_busy;

    modport master (
        input  fifo_empty, fifo_dout, t_r, pipe_busy,
        output fifo_rd_en, triangle_coords, tri_valid
    );

    modport slave (
        output fifo_empty, fifo_dout, t_r, pipe_busy,
        input  fifo_rd_en, triangle_coords, tri_valid
    );

endinterface

// File: rtl/tri_degen_check.sv
// Flags a triangle whose vertices share an (x,y) position in any pair; z is ignored.
// Purely combinational, zero latency, no flow control.
module tri_degen_check
    import tri_sched_pkg::*;
(
    input  triangle_t tri_in,
    output logic      degen
);

    function automatic logic same_xy(input vertex_t a, input vertex_t b);
        return (a.x == b.x) && (a.y == b.y);
    endfunction

    assign degen = same_xy(tri_in[0], tri_in[1])
                || same_xy(tri_in[1], tri_in[2])
                || same_xy(tri_in[0], tri_in[2]);

endmodule

// File: rtl/triangle_scheduler.sv
// Per-frame sequencer: clear back buffer, stream FIFO triangles to the pipeline, swap on vsync.
// One triangle in flight; tri_valid waits on t_r, FETCH stalls on fifo_empty. TRI_DEGEN_CULL_EN drops degenerate triangles.
module triangle_scheduler
    import tri_sched_pkg::*;
#(
    parameter int FIFO_RD_LAT = 1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_100MHz,
    input  logic                 reset_ah,
    triangle_scheduler_if.master bus,
    input  logic                 vsync_n,
    output logic                 clear_start,
    input  logic                 clear_done,
    output logic                 buf_sel,
    output logic                 buf_swap,
    output logic [CNT_W-1:0]     tri_count,
    output logic                 frame_overrun
`ifdef TRI_DEGEN_CULL_EN
    ,
    output logic                 cull_pulse
`endif
);

    localparam logic [1:0] RD_LAT = 2'(FIFO_RD_LAT);

    sched_state_t state, state_d;
    logic         vs_q;
    logic [1:0]   wait_cnt;
    logic         vs_edge;
    logic         rd_done;
    logic         is_marker;
    logic         drop_tri;
    logic         rd_en_d;
    logic         clear_start_d;
    logic         buf_swap_d;
    logic         overrun_d;
    logic         load_tri;
    logic         accept;
    logic         zero_count;

    assign vs_edge   = vs_q & ~vsync_n;
    assign rd_done   = (state == WAIT_RD) && (wait_cnt == RD_LAT);
    assign is_marker = (bus.fifo_dout == EOF_MARKER);

`ifdef TRI_DEGEN_CULL_EN
    tri_degen_check u_degen (
        .tri_in (bus.fifo_dout),
        .degen  (drop_tri)
    );

    always_ff @(posedge clk_100MHz) begin
        if (reset_ah) cull_pulse <= 1'b0;
        else          cull_pulse <= rd_done && !is_marker && drop_tri;
    end
`else
    assign drop_tri = 1'b0;
`endif

    always_comb begin
        state_d       = state;
        rd_en_d       = 1'b0;
        // After a swap the clear request follows one cycle behind buf_swap.
        clear_start_d = buf_swap;
        buf_swap_d    = 1'b0;
        overrun_d     = 1'b0;
        load_tri      = 1'b0;
        accept        = 1'b0;
        zero_count    = 1'b0;
        unique case (state)
            WAIT_VS: begin
                if (vs_edge) begin
                    clear_start_d = 1'b1;
                    state_d       = CLEAR;
                end
            end
            CLEAR: begin
                // Ignore clear_done until the clear request has actually gone out.
                if (clear_done && !buf_swap) begin
                    zero_count = 1'b1;
                    state_d    = FETCH;
                end
            end
            FETCH: begin
                if (!bus.fifo_empty) begin
                    rd_en_d = 1'b1;
                    state_d = WAIT_RD;
                end
            end
            WAIT_RD: begin
                if (rd_done) begin
                    if (is_marker)     state_d = DRAIN;
                    else if (drop_tri) state_d = FETCH;
                    else begin
                        load_tri = 1'b1;
                        state_d  = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (bus.t_r) begin
                    accept  = 1'b1;
                    state_d = FETCH;
                end
            end
            DRAIN: begin
                if (!bus.pipe_busy) state_d = WAIT_SWAP;
            end
            WAIT_SWAP: begin
                if (vs_edge) begin
                    buf_swap_d = 1'b1;
                    state_d    = CLEAR;
                end
            end
            default: state_d = WAIT_VS;
        endcase
        // A vsync that lands while the frame is still being drawn (including the DRAIN exit cycle) is missed.
        if (vs_edge && (state != WAIT_VS) && (state != WAIT_SWAP)) overrun_d = 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (reset_ah) begin
            state               <= WAIT_VS;
            vs_q                <= 1'b1;
            wait_cnt            <= 2'd0;
            bus.fifo_rd_en      <= 1'b0;
            bus.tri_valid       <= 1'b0;
            bus.triangle_coords <= '0;
            clear_start         <= 1'b0;
            buf_swap            <= 1'b0;
            buf_sel             <= 1'b0;
            frame_overrun       <= 1'b0;
            tri_count           <= '0;
        end else begin
            state          <= state_d;
            vs_q           <= vsync_n;
            bus.fifo_rd_en <= rd_en_d;
            clear_start    <= clear_start_d;
            buf_swap       <= buf_swap_d;
            frame_overrun  <= overrun_d;
            if (rd_en_d)                wait_cnt <= 2'd0;
            else if (state == WAIT_RD)  wait_cnt <= wait_cnt + 2'd1;
            if (load_tri) begin
                bus.triangle_coords <= bus.fifo_dout;
                bus.tri_valid       <= 1'b1;
            end else if (accept) begin
                bus.tri_valid       <= 1'b0;
            end
            if (buf_swap_d) buf_sel <= ~buf_sel;
            if (zero_count)                      tri_count <= '0;
            else if (accept && (tri_count != '1)) tri_count <= tri_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_triangle_scheduler.sv
// Directed bench for triangle_scheduler: FIFO model, triangle scoreboard and per-cycle protocol checks.
module tb_triangle_scheduler;

    localparam int LAT = 1;
    localparam int CW  = 16;
`ifdef TRI_DEGEN_CULL_EN
    localparam bit CULL = 1'b1;
`else
    localparam bit CULL = 1'b0;
`endif

    localparam logic [95:0] T1 = 96'h00902007_00601404_00300801;
    localparam logic [95:0] T2 = 96'h00A03009_00C0400B_00E0500D;
    localparam logic [95:0] T3 = 96'h00000111_00000222_00000333;
    localparam logic [95:0] T4 = 96'h12345678_9ABCDEF0_0F1E2D3C;
    localparam logic [95:0] T5 = 96'h00000001_00000002_00000003;
    localparam logic [95:0] TD = 96'h00332064_00901C05_00101C05;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_ah;
    logic          vsync_n;
    logic          clear_start;
    logic          clear_done;
    logic          buf_sel;
    logic          buf_swap;
    logic [CW-1:0] tri_count;
    logic          frame_overrun;
`ifdef TRI_DEGEN_CULL_EN
    logic          cull_pulse;
`endif

    triangle_scheduler_if bus();

    triangle_scheduler #(.FIFO_RD_LAT(LAT), .CNT_W(CW)) dut (
        .clk_100MHz    (clk),
        .reset_ah      (reset_ah),
        .bus           (bus),
        .vsync_n       (vsync_n),
        .clear_start   (clear_start),
        .clear_done    (clear_done),
        .buf_sel       (buf_sel),
        .buf_swap      (buf_swap),
        .tri_count     (tri_count),
        .frame_overrun (frame_overrun)
`ifdef TRI_DEGEN_CULL_EN
        ,
        .cull_pulse    (cull_pulse)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_degen(input logic [95:0] w);
        logic [9:0] xs [3];
        logic [9:0] ys [3];
        for (int i = 0; i < 3; i++) begin
            xs[i] = w[32*i +: 10];
            ys[i] = w[32*i+10 +: 10];
        end
        return (xs[0] == xs[1] && ys[0] == ys[1]) ||
               (xs[1] == xs[2] && ys[1] == ys[2]) ||
               (xs[0] == xs[2] && ys[0] == ys[2]);
    endfunction

    // FIFO contents and the triangles the pipeline must receive, in order.
    logic [95:0] fq [$];
    logic [95:0] sb [$];
    logic [95:0] rd_pipe [LAT];

    always @(posedge clk) begin
        if (bus.fifo_rd_en === 1'b1) begin
            chk("fifo_underflow", fq.size() == 0, 1'b0);
            if (fq.size() > 0) rd_pipe[0] <= fq.pop_front();
        end
        for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.fifo_dout = rd_pipe[LAT-1];

    always @(negedge clk) bus.fifo_empty <= (fq.size() == 0);

    task automatic push(input logic [95:0] w);
        fq.push_back(w);
        if (w != 96'h0 && !(CULL && is_degen(w))) sb.push_back(w);
    endtask

    // Per-cycle protocol checks and event counters.
    logic        p_valid = 1'b0, p_tr = 1'b0, p_rden = 1'b0;
    logic [95:0] p_coords = '0;
    int frame_xfers = 0;
    int cyc = 0, n_clear = 0, n_swap = 0, n_overrun = 0, n_rd = 0, n_cull = 0;
    int swap_cyc = 0, clear_cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (reset_ah) begin
            p_valid = 1'b0;
            p_tr = 1'b0;
            p_rden = 1'b0;
            frame_xfers = 0;
        end else begin
            if (bus.tri_valid) chk("marker_never_valid", bus.triangle_coords == 96'h0, 1'b0);
            if (p_valid && !p_tr) begin
                chk("hold_valid", bus.tri_valid, 1'b1);
                chk("hold_coords", bus.triangle_coords, p_coords);
            end
            if (p_rden) chk("rd_en_single_cycle", bus.fifo_rd_en, 1'b0);
            if (bus.fifo_rd_en) begin
                n_rd++;
                chk("count_at_fetch", tri_count, frame_xfers);
            end
            if (clear_start) begin
                n_clear++;
                clear_cyc = cyc;
                frame_xfers = 0;
            end
            if (buf_swap) begin
                n_swap++;
                swap_cyc = cyc;
            end
            if (frame_overrun) n_overrun++;
`ifdef TRI_DEGEN_CULL_EN
            if (cull_pulse) n_cull++;
`endif
            if (bus.tri_valid && bus.t_r) begin
                chk("sb_nonempty", sb.size() != 0, 1'b1);
                if (sb.size() != 0) chk("xfer_coords", bus.triangle_coords, sb.pop_front());
                frame_xfers++;
            end
            p_valid  = bus.tri_valid;
            p_tr     = bus.t_r;
            p_coords = bus.triangle_coords;
            p_rden   = bus.fifo_rd_en;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_vs();
        vsync_n = 1'b0;
        repeat (3) tick();
        vsync_n = 1'b1;
        tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (bus.tri_valid !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        chk(name, bus.tri_valid, 1'b1);
    endtask

    task automatic accept();
        bus.t_r = 1'b1;
        tick();
        bus.t_r = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0, s0, o0, lat;
        reset_ah      = 1'b1;
        vsync_n       = 1'b1;
        clear_done    = 1'b0;
        bus.t_r       = 1'b0;
        bus.pipe_busy = 1'b0;
        repeat (3) tick();
        chk("rst_tri_valid", bus.tri_valid, 1'b0);
        chk("rst_coords", bus.triangle_coords, 96'h0);
        chk("rst_buf_sel", buf_sel, 1'b0);
        chk("rst_tri_count", tri_count, 16'h0);
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        chk("rst_clear_start", clear_start, 1'b0);
        chk("rst_buf_swap", buf_swap, 1'b0);
        chk("rst_overrun", frame_overrun, 1'b0);
        reset_ah = 1'b0;

        // Frame 1: three triangles plus marker, clear held off for ~12 cycles.
        push(T1); push(T2); push(T3); push(96'h0);
        repeat (2) tick();
        c0 = n_clear;
        r0 = n_rd;
        pulse_vs();
        repeat (8) tick();
        chk("clear_start_once", n_clear - c0, 1);
        chk("no_fetch_before_done", n_rd - r0, 0);
        clear_done = 1'b1;
        lat = 0;
        while (bus.fifo_rd_en !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("rd_en_after_done", lat, 2);
        lat = 0;
        while (bus.tri_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        chk("valid_latency", lat, LAT + 1);
        chk("t1_coords", bus.triangle_coords, T1);

        bus.pipe_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_valid("bp_valid");
            repeat (5) tick();
            accept();
        end
        repeat (6) tick();
        s0 = n_swap;
        o0 = n_overrun;
        pulse_vs();
        repeat (10) tick();
        chk("no_swap_while_busy", n_swap - s0, 0);
        chk("drain_vs_overrun", n_overrun - o0, 1);
        chk("busy_buf_sel", buf_sel, 1'b0);
        chk("frame1_count", tri_count, 16'd3);
        bus.pipe_busy = 1'b0;
        repeat (3) tick();
        s0 = n_swap;
        pulse_vs();
        tick();
        chk("swap1", n_swap - s0, 1);
        chk("buf_sel_after_swap1", buf_sel, 1'b1);
        chk("clear_after_swap", clear_cyc - swap_cyc, 1);

        // Frame 2: degenerate triangle, then overrun while a triangle waits in ISSUE.
        push(TD); push(T4); push(96'h0);
        wait_valid("f2_first");
`ifndef TRI_DEGEN_CULL_EN
        chk("degen_issued", bus.triangle_coords, TD);
        accept();
        wait_valid("f2_t4");
`endif
        s0 = n_swap;
        o0 = n_overrun;
        pulse_vs();
        chk("overrun_in_issue", n_overrun - o0, 1);
        chk("overrun_no_swap", n_swap - s0, 0);
        chk("overrun_buf_sel", buf_sel, 1'b1);
        accept();
        repeat (8) tick();
        chk("frame2_count", tri_count, CULL ? 16'd1 : 16'd2);
`ifdef TRI_DEGEN_CULL_EN
        chk("cull_pulses", n_cull, 1);
`endif
        s0 = n_swap;
        pulse_vs();
        tick();
        chk("swap2", n_swap - s0, 1);
        chk("buf_sel_after_swap2", buf_sel, 1'b0);

        // Frame 3: FIFO empty for 100 cycles, then only the marker.
        repeat (3) tick();
        r0 = n_rd;
        repeat (100) tick();
        chk("empty_no_rd_en", n_rd - r0, 0);
        push(96'h0);
        repeat (8) tick();
        chk("frame3_count", tri_count, 16'd0);
        s0 = n_swap;
        pulse_vs();
        tick();
        chk("swap3", n_swap - s0, 1);
        chk("buf_sel_after_swap3", buf_sel, 1'b1);

        // Frame 4: reset while a triangle sits in ISSUE.
        push(T5);
        wait_valid("f4_valid");
        chk("total_clear_starts", n_clear, 4);
        chk("total_swaps", n_swap, 3);
        chk("total_overruns", n_overrun, 2);
        reset_ah = 1'b1;
        tick();
        fq.delete();
        sb.delete();
        chk("rst_mid_tri_valid", bus.tri_valid, 1'b0);
        chk("rst_mid_buf_sel", buf_sel, 1'b0);
        chk("rst_mid_tri_count", tri_count, 16'h0);
        reset_ah = 1'b0;
        repeat (5) tick();
        chk("idle_after_reset", bus.tri_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/triangle_scheduler.md
Name: triangle_scheduler

Overview:
- Sequences the triangle_pipeline over each video frame.
- Pops packed 96-bit triangles from the triangle FIFO and hands them to the pipeline with a valid/ready handshake.
- Triggers the framebuffer clear engine and swaps the double-buffered framebuffer on the vertical-sync boundary.
- Sits between the triangle FIFO and triangle_pipeline, in the clk_100MHz domain.

Parameters:
- FIFO_RD_LAT, 1: cycles from fifo_rd_en to valid fifo_dout (1..3).
- CNT_W, 16: width of the per-frame triangle counter.

Ports:
- clk_100MHz  in  1  system clock
- reset_ah  in  1  synchronous active-high reset
- fifo_empty  in  1  triangle FIFO empty
- fifo_rd_en  out  1  single-cycle FIFO pop
- fifo_dout  in  96  popped triangle word
- vsync_n  in  1  vertical sync, active low, already synchronised to clk_100MHz
- triangle_coords  out  96  triangle to pipeline; v0 x[9:0] y[19:10] z[31:20], v1 [41:32] [51:42] [63:52], v2 [73:64] [83:74] [95:84]
- tri_valid  out  1  triangle_coords valid
- t_r  in  1  pipeline ready to accept a triangle
- pipe_busy  in  1  pipeline still rasterising
- clear_start  out  1  single-cycle pulse that starts the back-buffer clear
- clear_done  in  1  clear engine finished (level, sampled only in CLEAR)
- buf_sel  out  1  back-buffer index being drawn; display buffer = ~buf_sel
- buf_swap  out  1  single-cycle pulse when buf_sel toggles
- tri_count  out  CNT_W  triangles issued this frame, saturating at all-ones
- frame_overrun  out  1  single-cycle pulse on a missed vsync deadline

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state=WAIT_VS, all pulses 0, tri_valid=0, triangle_coords=0, buf_sel=0, tri_count=0.
- Reset mid-operation: abandons any in-flight triangle; the FIFO is not flushed by this block.
- vs_edge: falling edge of vsync_n, detected against a registered copy. The registered copy resets to 1.
- End-of-frame marker: fifo_dout == 96'h0. This word is reserved, is never issued to the pipeline, and is not counted.

State machine:
- WAIT_VS: on vs_edge -> CLEAR with clear_start=1.
- CLEAR: wait for clear_done=1; then tri_count<=0 -> FETCH.
- FETCH: if !fifo_empty, assert fifo_rd_en for exactly one cycle -> WAIT_RD. If the FIFO is empty, stay in FETCH.
- WAIT_RD: after FIFO_RD_LAT cycles, latch fifo_dout.
  - Marker word -> DRAIN.
  - Otherwise -> ISSUE with triangle_coords loaded and tri_valid=1.
- ISSUE: tri_valid held high and triangle_coords held stable until the cycle where tri_valid && t_r.
  - In that cycle the transfer occurs.
  - Next cycle: tri_valid=0, tri_count increments (saturating) -> FETCH.
- DRAIN: wait for pipe_busy=0 -> WAIT_SWAP.
- WAIT_SWAP: on vs_edge, buf_sel toggles and buf_swap=1 in the same cycle; clear_start=1 on the next cycle -> CLEAR.

Timing and boundary rules:
- Latency: the earliest fifo_rd_en comes 1 cycle after entering FETCH. The earliest tri_valid comes FIFO_RD_LAT+1 cycles after fifo_rd_en.
- Overrun: a vs_edge in any state other than WAIT_VS/WAIT_SWAP pulses frame_overrun.
  - buf_sel is unchanged and the display repeats the previous frame.
  - The FSM continues and swaps on the next vs_edge after reaching WAIT_SWAP.
- fifo_empty during FETCH: no read is issued; the FSM waits indefinitely.
- vs_edge in the same cycle as reaching WAIT_SWAP (the DRAIN->WAIT_SWAP transition) is not a swap. It counts as an overrun.
- Handshake: t_r asserted while tri_valid=0 has no effect. Only one triangle is outstanding, so there is no skid buffer.

Optional Feature:
- Macro: TRI_DEGEN_CULL_EN.
- Defined: in WAIT_RD, a non-marker triangle whose two vertices share identical (x,y) is dropped.
  - Applies to any pair: v0/v1, v1/v2 or v0/v2.
  - The FSM returns to FETCH without tri_valid and without incrementing tri_count.
  - A 1-cycle cull_pulse output port exists.
- Undefined: every non-marker triangle is issued, and the cull_pulse port is absent.

Decomposition:
- Package tri_sched_pkg contains:
  - vertex_t: packed struct, x[9:0], y[9:0], z[11:0].
  - triangle_t: packed array of 3 vertex_t, total 96 bits, v0 in the LSBs.
  - EOF_MARKER constant: 96'h0.
  - sched_state_t enum: WAIT_VS, CLEAR, FETCH, WAIT_RD, ISSUE, DRAIN, WAIT_SWAP.
- Sub-module tri_degen_check: combinational compare of the three vertex (x,y) pairs. Instantiated only under TRI_DEGEN_CULL_EN.

Test Plan:
- Reset, then vs_edge:
  - clear_start pulses once.
  - Hold clear_done=0 for 10 cycles: no fifo_rd_en appears.
  - clear_done=1 -> fifo_rd_en on the next FETCH cycle.
- Backpressure: FIFO holds 3 triangles plus the marker; t_r stalls 5 cycles per triangle.
  - triangle_coords stays stable while stalled.
  - tri_count=3.
  - The marker is never valid.
- End of frame: with pipe_busy=1 for 20 cycles after the marker, then vs_edge:
  - No swap occurs before pipe_busy falls.
  - After the next vs_edge: buf_sel 0->1, buf_swap pulses, then clear_start pulses.
- Overrun: vs_edge while in ISSUE -> frame_overrun pulses, buf_sel is unchanged, and the swap happens on the following vs_edge.
- Empty FIFO: fifo_empty=1 for 100 cycles -> fifo_rd_en stays 0. Sync reset asserted while in ISSUE -> tri_valid=0 and buf_sel=0 the next cycle.
- TRI_DEGEN_CULL_EN: a triangle with v0=v1=(5,7) -> cull_pulse=1, no tri_valid, tri_count unchanged. Without the macro, the same triangle is issued.
